// File: rtl/hazard_ctrl.sv
//------------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage core. Each cycle it decides
// whether PC, IF/ID, ID/EX and EX/MEM advance, hold, or take a bubble. It
// handles load-use hazards, the multi-cycle divider occupying EX, and
// data-memory wait states.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : a memory stall lasting MEM_TIMEOUT cycles sets the sticky
//               mem_err flag and the pipeline is released from then on
//   undefined : no timeout, mem_err is tied 0
//
// Parameters
//   DIV_CYCLES  total EX-occupancy cycles of a div/divu (>= 2)
//   CNT_W       divide counter width (2**CNT_W > DIV_CYCLES)
//   MEM_TIMEOUT stall cycles before timeout (1..255, MEM_TIMEOUT_EN only)
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-low reset
//   id_Rs, id_Rt   source register fields of the ID instruction
//   id_use_rs/rt   ID instruction actually reads Rs / Rt
//   ex_MemRead     EX instruction is a load
//   ex_wreg        EX destination register
//   ex_div_start   EX instruction is div/divu
//   mem_req        MEM stage has an active data-memory access
//   mem_ready      data memory completes the access this cycle
//   pc_hold, if_id_hold, id_ex_hold, ex_mem_hold   stage hold controls
//   id_ex_bubble   ID/EX loads a NOP (drives stall_id_ex)
//   mem_wb_bubble  MEM/WB loads a NOP
//   div_busy       controller is in S_DIV
//   div_done       divide result valid this cycle
//   mem_err        sticky memory timeout flag
//------------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_Rs,
   input  logic [4:0] id_Rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       ex_MemRead,
   input  logic [4:0] ex_wreg,
   input  logic       ex_div_start,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       pc_hold,
   output logic       if_id_hold,
   output logic       id_ex_hold,
   output logic       id_ex_bubble,
   output logic       ex_mem_hold,
   output logic       mem_wb_bubble,
   output logic       div_busy,
   output logic       div_done,
   output logic       mem_err
);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_DIV  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Reject unusable parameter sets at elaboration time.
   generate
      if ((DIV_CYCLES < 2) || ((64'd1 << CNT_W) <= 64'(DIV_CYCLES)) ||
          (MEM_TIMEOUT < 1) || (MEM_TIMEOUT > 255)) begin : g_bad_param
         $error("hazard_ctrl: illegal DIV_CYCLES/CNT_W/MEM_TIMEOUT");
      end
   endgenerate

   // True when the EX load writes a register the ID instruction reads.
   function automatic logic load_use_f(
      input logic       mem_read,
      input logic [4:0] wreg,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       use_rs,
      input logic       use_rt
   );
      load_use_f = mem_read && (wreg != 5'd0) &&
                   ((use_rs && (rs == wreg)) || (use_rt && (rt == wreg)));
   endfunction

   state_t           state_r, state_nxt_s;
   logic [CNT_W-1:0] div_cnt_r, div_cnt_nxt_s;
   logic [7:0]       wait_cnt_r, wait_cnt_nxt_s;
   logic             mem_err_r, mem_err_nxt_s;

   logic raw_stall_s, mem_stall_s, load_use_s;
   logic pc_hold_s, if_id_hold_s, id_ex_hold_s, id_ex_bubble_s;
   logic ex_mem_hold_s, mem_wb_bubble_s;

   assign raw_stall_s = mem_req & ~mem_ready;
   assign load_use_s  = load_use_f(ex_MemRead, ex_wreg, id_Rs, id_Rt,
                                   id_use_rs, id_use_rt);

`ifdef MEM_TIMEOUT_EN
   logic timeout_hit_s;
   // Once the flag is set the memory is considered dead and never stalls us.
   assign timeout_hit_s = raw_stall_s & ~mem_err_r &
                          (wait_cnt_r == 8'(MEM_TIMEOUT));
   assign mem_stall_s   = raw_stall_s & ~mem_err_r & ~timeout_hit_s;
   assign mem_err_nxt_s = mem_err_r | timeout_hit_s;
`else
   assign mem_stall_s   = raw_stall_s;
   assign mem_err_nxt_s = 1'b0;
`endif

   // Next-state, divide counter and raw hold/bubble decode.
   always_comb begin
      state_nxt_s     = state_r;
      div_cnt_nxt_s   = div_cnt_r;
      pc_hold_s       = 1'b0;
      if_id_hold_s    = 1'b0;
      id_ex_hold_s    = 1'b0;
      id_ex_bubble_s  = 1'b0;
      ex_mem_hold_s   = 1'b0;
      mem_wb_bubble_s = 1'b0;
      if (mem_stall_s) begin
         // Memory wait freezes everything; hold wins over any bubble.
         pc_hold_s       = 1'b1;
         if_id_hold_s    = 1'b1;
         id_ex_hold_s    = 1'b1;
         ex_mem_hold_s   = 1'b1;
         mem_wb_bubble_s = 1'b1;
      end else begin
         case (state_r)
            S_RUN: begin
               if (ex_div_start) begin
                  pc_hold_s       = 1'b1;
                  if_id_hold_s    = 1'b1;
                  id_ex_hold_s    = 1'b1;
                  ex_mem_hold_s   = 1'b1;
                  mem_wb_bubble_s = 1'b1;
                  div_cnt_nxt_s   = CNT_W'(DIV_CYCLES - 1);
                  state_nxt_s     = S_DIV;
               end else if (load_use_s) begin
                  pc_hold_s      = 1'b1;
                  if_id_hold_s   = 1'b1;
                  id_ex_bubble_s = 1'b1;
               end else begin
                  state_nxt_s = S_RUN;
               end
            end
            S_DIV: begin
               pc_hold_s       = 1'b1;
               if_id_hold_s    = 1'b1;
               id_ex_hold_s    = 1'b1;
               ex_mem_hold_s   = 1'b1;
               mem_wb_bubble_s = 1'b1;
               // <= 1 also catches a corrupted zero count instead of wrapping.
               if (div_cnt_r <= CNT_W'(1)) begin
                  div_cnt_nxt_s = '0;
                  state_nxt_s   = S_DONE;
               end else begin
                  div_cnt_nxt_s = div_cnt_r - CNT_W'(1);
                  state_nxt_s   = S_DIV;
               end
            end
            S_DONE: begin
               // The finished div leaves EX now, so ex_div_start is stale.
               state_nxt_s = S_RUN;
               if (load_use_s) begin
                  pc_hold_s      = 1'b1;
                  if_id_hold_s   = 1'b1;
                  id_ex_bubble_s = 1'b1;
               end else begin
                  pc_hold_s = 1'b0;
               end
            end
            default: begin
               state_nxt_s   = S_RUN;
               div_cnt_nxt_s = '0;
            end
         endcase
      end
   end

   // Wait-cycle counter: saturating while stalled, cleared otherwise.
   always_comb begin
      wait_cnt_nxt_s = 8'd0;
      if (mem_stall_s && (wait_cnt_r != 8'hFF)) begin
         wait_cnt_nxt_s = wait_cnt_r + 8'd1;
      end else if (mem_stall_s) begin
         wait_cnt_nxt_s = wait_cnt_r;
      end else begin
         wait_cnt_nxt_s = 8'd0;
      end
   end

   // State, counters and sticky error register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= S_RUN;
         div_cnt_r  <= '0;
         wait_cnt_r <= 8'd0;
         mem_err_r  <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         div_cnt_r  <= div_cnt_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
         mem_err_r  <= mem_err_nxt_s;
      end
   end

   // Outputs are forced low while reset is asserted.
   assign pc_hold       = rst & pc_hold_s;
   assign if_id_hold    = rst & if_id_hold_s;
   assign id_ex_hold    = rst & id_ex_hold_s;
   assign id_ex_bubble  = rst & id_ex_bubble_s;
   assign ex_mem_hold   = rst & ex_mem_hold_s;
   assign mem_wb_bubble = rst & mem_wb_bubble_s;
   assign div_busy      = rst & (state_r == S_DIV);
   assign div_done      = rst & (state_r == S_DONE);
   assign mem_err       = rst & mem_err_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   // Output vector order:
   // {pc_hold, if_id_hold, id_ex_hold, id_ex_bubble, ex_mem_hold,
   //  mem_wb_bubble, div_busy, div_done, mem_err}
   localparam logic [8:0] NONE   = 9'b000000000;
   localparam logic [8:0] LU     = 9'b110100000;
   localparam logic [8:0] DIVH   = 9'b111011000;
   localparam logic [8:0] DIVB   = 9'b111011100;
   localparam logic [8:0] DONE   = 9'b000000010;
   localparam logic [8:0] DONELU = 9'b110100010;
   localparam logic [8:0] MEMS   = 9'b111011000;
   localparam logic [8:0] MEMSD  = 9'b111011100;
   localparam logic [8:0] MEMSF  = 9'b111011010;
   localparam logic [8:0] ERR    = 9'b000000001;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_Rs, id_Rt, ex_wreg;
   logic       id_use_rs, id_use_rt, ex_MemRead, ex_div_start;
   logic       mem_req, mem_ready;
   logic       pc_hold, if_id_hold, id_ex_hold, id_ex_bubble, ex_mem_hold;
   logic       mem_wb_bubble, div_busy, div_done, mem_err;

   int vectors = 0;
   int miscompares = 0;
   logic [8:0] exp_q[$];

   hazard_ctrl #(.DIV_CYCLES(4), .CNT_W(6), .MEM_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .id_Rs(id_Rs), .id_Rt(id_Rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_MemRead(ex_MemRead), .ex_wreg(ex_wreg),
      .ex_div_start(ex_div_start),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_hold(id_ex_hold),
      .id_ex_bubble(id_ex_bubble), .ex_mem_hold(ex_mem_hold),
      .mem_wb_bubble(mem_wb_bubble), .div_busy(div_busy),
      .div_done(div_done), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, queue its expectation, check mid-cycle.
   task automatic apply(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic mr,
                        input logic [4:0] wr, input logic dv, input logic rq,
                        input logic rd, input logic [8:0] exp, input string tag);
      logic [8:0] obs;
      logic [8:0] e;
      @(negedge clk);
      rst = r; id_Rs = rs; id_Rt = rt; id_use_rs = urs; id_use_rt = urt;
      ex_MemRead = mr; ex_wreg = wr; ex_div_start = dv;
      mem_req = rq; mem_ready = rd;
      exp_q.push_back(exp);
      #2;
      obs = {pc_hold, if_id_hold, id_ex_hold, id_ex_bubble, ex_mem_hold,
             mem_wb_bubble, div_busy, div_done, mem_err};
      e = exp_q.pop_front();
      vectors++;
      assert (obs === e) else begin
         miscompares++;
         $error("FAIL %s: observed %b required %b", tag, obs, e);
      end
   endtask

   task automatic idle(input logic [8:0] exp, input string tag);
      apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp, tag);
   endtask

   task automatic divs(input logic [8:0] exp, input string tag);
      apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, exp, tag);
   endtask

   task automatic mstall(input logic [8:0] exp, input string tag);
      apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, exp, tag);
   endtask

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; id_Rs = 5'd0; id_Rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      ex_MemRead = 1'b0; ex_wreg = 5'd0; ex_div_start = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;

      // Reset with every hazard source active: outputs must all be 0.
      apply(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, NONE, "reset_0");
      apply(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, NONE, "reset_1");
      idle(NONE, "idle_after_reset");

      // Load-use on Rs, then clear.
      apply(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LU, "lu_rs");
      idle(NONE, "lu_clears");
      // Destination r0 never causes a hazard.
      apply(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NONE, "lu_r0");
      // Load-use on Rt; same with use_rt=0 gives nothing; non-load gives nothing.
      apply(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, LU, "lu_rt");
      apply(1'b1, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, NONE, "lu_rt_unused");
      apply(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, NONE, "lu_not_load");

      // Divide with ex_div_start held: 4 hold cycles, then done (start ignored).
      divs(DIVH, "div_c1");
      divs(DIVB, "div_c2");
      divs(DIVB, "div_c3");
      divs(DIVB, "div_c4");
      divs(DONE, "div_done");
      idle(NONE, "div_back_run");

      // Memory wait 3 cycles, with a load-use pending in the middle one.
      mstall(MEMS, "mem_w1");
      apply(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, MEMS, "mem_w2_lu");
      mstall(MEMS, "mem_w3");
      apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NONE, "mem_ready");

      // Overlap: div start with load-use inputs (div wins), 2 stall cycles in S_DIV.
      apply(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, DIVH, "ov_start_prio");
      idle(DIVB, "ov_div1");
      mstall(MEMSD, "ov_stall1");
      mstall(MEMSD, "ov_stall2");
      idle(DIVB, "ov_div2");
      idle(DIVB, "ov_div3");
      idle(DONE, "ov_done");
      idle(NONE, "ov_run");

      // Stall while in S_DONE keeps div_done high; load-use acts in the DONE cycle.
      divs(DIVH, "sd_c1");
      idle(DIVB, "sd_c2");
      idle(DIVB, "sd_c3");
      idle(DIVB, "sd_c4");
      mstall(MEMSF, "sd_stall1");
      mstall(MEMSF, "sd_stall2");
      apply(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, DONELU, "sd_done_lu");
      idle(NONE, "sd_run");

      // Reset mid-divide at div_cnt==2 aborts without div_done.
      divs(DIVH, "rd_c1");
      divs(DIVB, "rd_c2");
      apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, NONE, "rd_reset");
      idle(NONE, "rd_after1");
      idle(NONE, "rd_after2");
      idle(NONE, "rd_after3");

`ifdef MEM_TIMEOUT_EN
      // Stuck memory: 8 stall cycles, release, then sticky mem_err.
      for (int i = 0; i < 8; i++) mstall(MEMS, "to_stall");
      mstall(NONE, "to_release");
      mstall(ERR, "to_err_sticky1");
      mstall(ERR, "to_err_sticky2");
      apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, NONE, "to_reset");
      mstall(MEMS, "to_stall_again");
      idle(NONE, "to_idle");
`else
      // Without the timeout a long stall never releases.
      for (int i = 0; i < 12; i++) mstall(MEMS, "long_stall");
      idle(NONE, "long_stall_end");
`endif

      vectors++;
      assert (exp_q.size() == 0) else begin
         miscompares++;
         $error("FAIL queue_empty: observed %0d entries required 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
